pito_test_monitor: RTL and testbench

PITO_TEST_MONITOR -- requirements
Module: pito_test_monitor

---
 rtl/pito_tm_pkg.sv | 30 +++
 rtl/pito_tm_hart_slot.sv | 39 +++
 rtl/pito_test_monitor.sv | 128 ++++++++++++
 tb/tb_pito_test_monitor.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pito_tm_pkg.sv
// Shared types for the PITO test monitor: FSM state encoding and tohost report decoding.
package pito_tm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } tm_state_e;

    typedef enum logic [1:0] {
        RPT_NONE = 2'd0,
        RPT_PASS = 2'd1,
        RPT_FAIL = 2'd2
    } report_e;

    // A tohost write is a report only when bit 0 is set; exactly 1 means pass.
    function automatic report_e decode_report(input logic valid,
                                              input logic odd,
                                              input logic upper_zero);
        if (!valid || !odd) begin
            return RPT_NONE;
        end
        if (upper_zero) begin
            return RPT_PASS;
        end
        return RPT_FAIL;
    endfunction

endpackage

// File: rtl/pito_tm_hart_slot.sv
// Per-hart result holder: keeps the first report of a run and flags a new failure.
module pito_tm_hart_slot
    import pito_tm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              done_o,
    output logic              fail_o,
    output logic              report_o,
    output logic              fail_strobe_o
);

    logic    done_q;
    logic    fail_q;
    report_e kind;

    assign kind          = decode_report(valid_i, data_i[0], data_i[DATA_W-1:1] == '0);
    assign report_o      = enable_i && !done_q && (kind != RPT_NONE);
    assign fail_strobe_o = report_o && (kind == RPT_FAIL);
    assign done_o        = done_q;
    assign fail_o        = fail_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (report_o) begin
            done_q <= 1'b1;
            fail_q <= (kind == RPT_FAIL);
        end
    end

endmodule

// File: rtl/pito_test_monitor.sv
// Collects tohost pass/fail reports from all harts, tracks run length and
// watchdog expiry, and records the lowest-index first failure.
module pito_test_monitor
    import pito_tm_pkg::*;
#(
    parameter int NUM_HARTS = 8,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [CNT_W-1:0]                   timeout_cycles,
    input  logic [NUM_HARTS-1:0]               tohost_valid,
    input  logic [NUM_HARTS-1:0][DATA_W-1:0]   tohost_data,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               timeout,
    output logic [NUM_HARTS-1:0]               hart_done_mask,
    output logic [NUM_HARTS-1:0]               fail_mask,
    output logic [HART_W-1:0]                  first_fail_hart,
    output logic [DATA_W-2:0]                  first_fail_code,
    output logic [CNT_W-1:0]                   cycle_count
);

    tm_state_e            state_q;
    logic                 busy_q, done_q, pass_q, timeout_q;
    logic [CNT_W-1:0]     count_q, count_d, limit_q;
    logic [HART_W-1:0]    ff_hart_q, ff_hart_d;
    logic [DATA_W-2:0]    ff_code_q, ff_code_d;
    logic [NUM_HARTS-1:0] report_vec, fail_strobe;
    logic                 clear, run, fail_any, all_done_d, limit_hit;

    assign run   = (state_q == ST_RUN);
    assign clear = start && !run;

    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_slot
        pito_tm_hart_slot #(.DATA_W(DATA_W)) u_slot (
            .clk          (clk),
            .rst          (rst),
            .clear_i      (clear),
            .enable_i     (run),
            .valid_i      (tohost_valid[gi]),
            .data_i       (tohost_data[gi]),
            .done_o       (hart_done_mask[gi]),
            .fail_o       (fail_mask[gi]),
            .report_o     (report_vec[gi]),
            .fail_strobe_o(fail_strobe[gi])
        );
    end

    // Descending scan so the lowest failing index is the one left standing.
    always_comb begin
        ff_hart_d = '0;
        ff_code_d = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            if (fail_strobe[i]) begin
                ff_hart_d = HART_W'(i);
                ff_code_d = tohost_data[i][DATA_W-1:1];
            end
        end
    end

    assign fail_any   = |fail_strobe;
    assign all_done_d = &(hart_done_mask | report_vec);
    assign limit_hit  = (limit_q != '0) && (count_q == limit_q - CNT_W'(1));
    assign count_d    = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
            limit_q   <= '0;
            ff_hart_q <= '0;
            ff_code_q <= '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    count_q <= count_d;
                    if (fail_any && (fail_mask == '0)) begin
                        ff_hart_q <= ff_hart_d;
                        ff_code_q <= ff_code_d;
                    end
                    // Completion wins over a watchdog expiring on the same cycle.
                    if (all_done_d) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= ((fail_mask | fail_strobe) == '0);
                    end else if (limit_hit) begin
                        state_q   <= ST_TIMEOUT;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        count_q   <= '0;
                        limit_q   <= timeout_cycles;
                        ff_hart_q <= '0;
                        ff_code_q <= '0;
                    end
                end
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign first_fail_hart = ff_hart_q;
    assign first_fail_code = ff_code_q;
    assign cycle_count     = count_q;

endmodule

// File: tb/tb_pito_test_monitor.sv
// Directed bench for pito_test_monitor: pass run, mixed failures, watchdog, syscall filtering, reset, tie-break.
module tb_pito_test_monitor;

    localparam int NH = 8;
    localparam int DW = 32;
    localparam int CW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [CW-1:0]         timeout_cycles;
    logic [NH-1:0]         tohost_valid;
    logic [NH-1:0][DW-1:0] tohost_data;
    logic                  busy, done, pass, timeout;
    logic [NH-1:0]         hart_done_mask, fail_mask;
    logic [2:0]            first_fail_hart;
    logic [DW-2:0]         first_fail_code;
    logic [CW-1:0]         cycle_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pito_test_monitor #(.NUM_HARTS(NH), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .timeout_cycles (timeout_cycles),
        .tohost_valid   (tohost_valid),
        .tohost_data    (tohost_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .hart_done_mask (hart_done_mask),
        .fail_mask      (fail_mask),
        .first_fail_hart(first_fail_hart),
        .first_fail_code(first_fail_code),
        .cycle_count    (cycle_count)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic report(input int hart, input logic [DW-1:0] val);
        tohost_valid[hart] = 1'b1;
        tohost_data[hart]  = val;
    endtask

    task automatic quiet();
        tohost_valid = '0;
        tohost_data  = '0;
    endtask

    task automatic do_start(input logic [CW-1:0] lim);
        start          = 1'b1;
        timeout_cycles = lim;
        tick(1);
        start          = 1'b0;
        timeout_cycles = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; timeout_cycles = '0; quiet();
        tick(2);
        rst = 1'b0;
        tick(1);
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_done",  64'(done), 64'd0);
        check("reset_mask",  64'(hart_done_mask), 64'd0);
        check("reset_count", 64'(cycle_count), 64'd0);

        // All harts pass, one per cycle, on RUN cycles 3..10.
        do_start(32'd0);
        check("t1_busy", 64'(busy), 64'd1);
        for (int r = 0; r <= 10; r++) begin
            if (r >= 3) report(r - 3, 32'd1);
            tick(1);
            quiet();
        end
        check("t1_done",  64'(done), 64'd1);
        check("t1_pass",  64'(pass), 64'd1);
        check("t1_fmask", 64'(fail_mask), 64'd0);
        check("t1_dmask", 64'(hart_done_mask), 64'hFF);
        check("t1_count", 64'(cycle_count), 64'd11);
        tick(3);
        check("t1_hold_count", 64'(cycle_count), 64'd11);
        check("t1_hold_done",  64'(done), 64'd1);

        // Simultaneous failures on harts 5 and 2; lowest index wins.
        do_start(32'd0);
        report(5, 32'd7); report(2, 32'h0B);
        tick(1); quiet();
        check("t2_fmask_early", 64'(fail_mask), 64'h24);
        check("t2_busy",        64'(busy), 64'd1);
        for (int h = 0; h < NH; h++) if (h != 2 && h != 5) report(h, 32'd1);
        tick(1); quiet();
        check("t2_done",  64'(done), 64'd1);
        check("t2_pass",  64'(pass), 64'd0);
        check("t2_fmask", 64'(fail_mask), 64'h24);
        check("t2_ffh",   64'(first_fail_hart), 64'd2);
        check("t2_ffc",   64'(first_fail_code), 64'd5);
        check("t2_count", 64'(cycle_count), 64'd2);

        // Watchdog of 100 with hart 3 silent; a start mid-run must be ignored.
        do_start(32'd100);
        for (int h = 0; h < NH; h++) if (h != 3) report(h, 32'd1);
        tick(1); quiet();
        tick(40);
        start = 1'b1; tick(1); start = 1'b0;
        tick(57);
        check("t3_pre_count",   64'(cycle_count), 64'd99);
        check("t3_pre_timeout", 64'(timeout), 64'd0);
        tick(1);
        check("t3_timeout", 64'(timeout), 64'd1);
        check("t3_done",    64'(done), 64'd1);
        check("t3_pass",    64'(pass), 64'd0);
        check("t3_busy",    64'(busy), 64'd0);
        check("t3_count",   64'(cycle_count), 64'd100);
        report(3, 32'd1);
        tick(1); quiet();
        check("t3_dmask", 64'(hart_done_mask), 64'hF7);

        // Report on the start-accept cycle is dropped; even data ignored; first report kept.
        report(1, 32'd3);
        do_start(32'd0);
        quiet();
        check("t4_accept_ignored", 64'(hart_done_mask), 64'd0);
        report(0, 32'd2); tick(1); quiet();
        check("t4_even", 64'(hart_done_mask), 64'd0);
        report(0, 32'd1); tick(1); quiet();
        check("t4_first_dmask", 64'(hart_done_mask), 64'h01);
        report(0, 32'd3); tick(1); quiet();
        check("t4_later_fmask", 64'(fail_mask), 64'd0);
        for (int h = 1; h < NH; h++) report(h, 32'd1);
        tick(1); quiet();
        check("t4_pass",  64'(pass), 64'd1);
        check("t4_fmask", 64'(fail_mask), 64'd0);

        // Reset mid-run after four reports, overriding start and a report.
        do_start(32'd0);
        for (int h = 0; h < 4; h++) report(h, 32'd1);
        tick(1); quiet();
        check("t5_dmask", 64'(hart_done_mask), 64'h0F);
        tick(2);
        rst = 1'b1; start = 1'b1; report(4, 32'd9);
        tick(1);
        rst = 1'b0; start = 1'b0; quiet();
        check("t5_rst_busy",  64'(busy), 64'd0);
        check("t5_rst_dmask", 64'(hart_done_mask), 64'd0);
        check("t5_rst_fmask", 64'(fail_mask), 64'd0);
        check("t5_rst_count", 64'(cycle_count), 64'd0);
        check("t5_rst_done",  64'(done), 64'd0);
        do_start(32'd0);
        for (int h = 0; h < NH; h++) report(h, 32'd1);
        tick(1); quiet();
        check("t5_pass",  64'(pass), 64'd1);
        check("t5_count", 64'(cycle_count), 64'd1);

        // Final report lands on the cycle the 20-cycle watchdog would fire.
        do_start(32'd20);
        for (int h = 0; h < 7; h++) report(h, 32'd1);
        tick(1); quiet();
        tick(18);
        check("t6_pre_busy", 64'(busy), 64'd1);
        report(7, 32'd1);
        tick(1); quiet();
        check("t6_done",    64'(done), 64'd1);
        check("t6_timeout", 64'(timeout), 64'd0);
        check("t6_pass",    64'(pass), 64'd1);
        check("t6_count",   64'(cycle_count), 64'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
